// File: rtl/ctrl_hazard_pipe_pkg.sv
// Shared encodings for the pipeline control/hazard block: field widths,
// forwarding selects, halt FSM states and the drain depth after BREAK.
package ctrl_hazard_pipe_pkg;
   localparam int REG_W   = 5;
   localparam int EXT_W   = 2;
   localparam int ALUOP_W = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic [1:0] {
      HALT_RUN    = 2'b00,
      HALT_DRAIN  = 2'b01,
      HALT_HALTED = 2'b10
   } halt_state_e;

   localparam logic [1:0] DRAIN_DEPTH = 2'd3;

   // A later stage supplies a value only if it writes a real (non-$0) register.
   function automatic logic reg_match(input logic             regw,
                                      input logic [REG_W-1:0] wreg,
                                      input logic [REG_W-1:0] src);
      return regw && (wreg != 5'd0) && (wreg == src);
   endfunction
endpackage

// File: rtl/ctrl_hazard_pipe_if.sv
// Control bundle between the decoder/front end and the hazard pipe:
// ID-stage decoder outputs in, stage controls and hazard selects out.
interface ctrl_hazard_pipe_if;
   import ctrl_hazard_pipe_pkg::*;

   logic               id_valid, id_jump, id_branch, id_nbranch, id_memr, id_mem2r;
   logic               id_memw, id_regw, id_alusrc, id_alushift, id_regdst, id_halt;
   logic [EXT_W-1:0]   id_extop;
   logic [ALUOP_W-1:0] id_aluctrl;
   logic [REG_W-1:0]   id_rs, id_rt, id_rd;
   logic               ex_zero;

   logic               pc_stall, ifid_stall, ifid_flush, branch_taken, jump_taken;
   logic               ex_branch, ex_nbranch, ex_memr, ex_mem2r, ex_memw, ex_regw;
   logic               ex_alusrc, ex_alushift;
   logic [EXT_W-1:0]   ex_extop;
   logic [ALUOP_W-1:0] ex_aluctrl;
   logic [REG_W-1:0]   ex_rs, ex_rt, ex_wreg;
   logic               mem_memr, mem_memw, mem_mem2r, mem_regw;
   logic [REG_W-1:0]   mem_wreg;
   logic               wb_regw, wb_mem2r;
   logic [REG_W-1:0]   wb_wreg;
   logic [1:0]         fwd_a, fwd_b;
   logic               halted;

   modport master (
      output id_valid, id_jump, id_branch, id_nbranch, id_memr, id_mem2r, id_memw,
             id_regw, id_alusrc, id_alushift, id_regdst, id_halt, id_extop,
             id_aluctrl, id_rs, id_rt, id_rd, ex_zero,
      input  pc_stall, ifid_stall, ifid_flush, branch_taken, jump_taken,
             ex_branch, ex_nbranch, ex_memr, ex_mem2r, ex_memw, ex_regw, ex_alusrc,
             ex_alushift, ex_extop, ex_aluctrl, ex_rs, ex_rt, ex_wreg,
             mem_memr, mem_memw, mem_mem2r, mem_regw, mem_wreg,
             wb_regw, wb_mem2r, wb_wreg, fwd_a, fwd_b, halted
   );

   modport slave (
      input  id_valid, id_jump, id_branch, id_nbranch, id_memr, id_mem2r, id_memw,
             id_regw, id_alusrc, id_alushift, id_regdst, id_halt, id_extop,
             id_aluctrl, id_rs, id_rt, id_rd, ex_zero,
      output pc_stall, ifid_stall, ifid_flush, branch_taken, jump_taken,
             ex_branch, ex_nbranch, ex_memr, ex_mem2r, ex_memw, ex_regw, ex_alusrc,
             ex_alushift, ex_extop, ex_aluctrl, ex_rs, ex_rt, ex_wreg,
             mem_memr, mem_memw, mem_mem2r, mem_regw, mem_wreg,
             wb_regw, wb_mem2r, wb_wreg, fwd_a, fwd_b, halted
   );
endinterface

// File: rtl/ctrl_hazard_pipe_fwd.sv
// Operand forwarding select for one EX source register; EX/MEM result
// takes precedence over MEM/WB because it is the younger write.
module fwd_unit
   import ctrl_hazard_pipe_pkg::*;
(
   input  logic [REG_W-1:0] i_src,
   input  logic             i_mem_regw,
   input  logic [REG_W-1:0] i_mem_wreg,
   input  logic             i_wb_regw,
   input  logic [REG_W-1:0] i_wb_wreg,
   output logic [1:0]       o_sel
);
   // Priority select between the two in-flight writers
   always_comb begin
      o_sel = FWD_RF;
      if (reg_match(i_mem_regw, i_mem_wreg, i_src)) begin
         o_sel = FWD_EXMEM;
      end else if (reg_match(i_wb_regw, i_wb_wreg, i_src)) begin
         o_sel = FWD_MEMWB;
      end else begin
         o_sel = FWD_RF;
      end
   end
endmodule

// File: rtl/ctrl_hazard_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch/jump
// flush, operand forwarding and the BREAK drain-and-halt sequence.
module ctrl_hazard_pipe
   import ctrl_hazard_pipe_pkg::*;
(
   input logic               clk,
   input logic               rst,
   ctrl_hazard_pipe_if.slave bus
);
   logic        w_rt_used, w_load_use, w_branch_taken, w_jump_taken;
   logic        w_halt_busy, w_bubble, w_start_drain;
   halt_state_e r_state;
   logic [1:0]  r_cnt;

   assign w_rt_used      = !bus.id_alusrc | bus.id_memw | bus.id_branch | bus.id_nbranch;
   assign w_load_use     = bus.ex_memr & (bus.ex_wreg != 5'd0) & bus.id_valid &
                           ((bus.ex_wreg == bus.id_rs) | (w_rt_used & (bus.ex_wreg == bus.id_rt)));
   assign w_branch_taken = (bus.ex_branch & bus.ex_zero) | (bus.ex_nbranch & !bus.ex_zero);
   assign w_jump_taken   = bus.id_valid & bus.id_jump & !w_load_use & !w_branch_taken;
   assign w_halt_busy    = (r_state != HALT_RUN);
   assign w_bubble       = w_branch_taken | w_load_use | w_halt_busy | !bus.id_valid;
   assign w_start_drain  = !w_halt_busy & bus.id_valid & bus.id_halt & !w_branch_taken & !w_load_use;

   // A taken branch overrides the load-use stall: the stalled instruction is wrong-path.
   assign bus.pc_stall     = (w_load_use & !w_branch_taken) | w_halt_busy;
   assign bus.ifid_stall   = (w_load_use & !w_branch_taken) | w_halt_busy;
   assign bus.ifid_flush   = w_branch_taken | w_jump_taken;
   assign bus.branch_taken = w_branch_taken;
   assign bus.jump_taken   = w_jump_taken;

   // ID/EX control register; a bubble is all-zero control and register fields
   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         bus.ex_branch   <= 1'b0;
         bus.ex_nbranch  <= 1'b0;
         bus.ex_memr     <= 1'b0;
         bus.ex_mem2r    <= 1'b0;
         bus.ex_memw     <= 1'b0;
         bus.ex_regw     <= 1'b0;
         bus.ex_alusrc   <= 1'b0;
         bus.ex_alushift <= 1'b0;
         bus.ex_extop    <= 2'd0;
         bus.ex_aluctrl  <= 5'd0;
         bus.ex_rs       <= 5'd0;
         bus.ex_rt       <= 5'd0;
         bus.ex_wreg     <= 5'd0;
      end else begin
         bus.ex_branch   <= bus.id_branch;
         bus.ex_nbranch  <= bus.id_nbranch;
         bus.ex_memr     <= bus.id_memr;
         bus.ex_mem2r    <= bus.id_mem2r;
         bus.ex_memw     <= bus.id_memw;
         bus.ex_regw     <= bus.id_regw & !w_jump_taken;
         bus.ex_alusrc   <= bus.id_alusrc;
         bus.ex_alushift <= bus.id_alushift;
         bus.ex_extop    <= bus.id_extop;
         bus.ex_aluctrl  <= bus.id_aluctrl;
         bus.ex_rs       <= bus.id_rs;
         bus.ex_rt       <= bus.id_rt;
         bus.ex_wreg     <= bus.id_regdst ? bus.id_rt : bus.id_rd;
      end
   end

   // EX/MEM and MEM/WB advance unconditionally
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_memr  <= 1'b0;
         bus.mem_memw  <= 1'b0;
         bus.mem_mem2r <= 1'b0;
         bus.mem_regw  <= 1'b0;
         bus.mem_wreg  <= 5'd0;
         bus.wb_regw   <= 1'b0;
         bus.wb_mem2r  <= 1'b0;
         bus.wb_wreg   <= 5'd0;
      end else begin
         bus.mem_memr  <= bus.ex_memr;
         bus.mem_memw  <= bus.ex_memw;
         bus.mem_mem2r <= bus.ex_mem2r;
         bus.mem_regw  <= bus.ex_regw;
         bus.mem_wreg  <= bus.ex_wreg;
         bus.wb_regw   <= bus.mem_regw;
         bus.wb_mem2r  <= bus.mem_mem2r;
         bus.wb_wreg   <= bus.mem_wreg;
      end
   end

   // Halt sequencer: drain the in-flight instructions, then hold until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= HALT_RUN;
         r_cnt      <= 2'd0;
         bus.halted <= 1'b0;
      end else begin
         case (r_state)
            HALT_RUN: begin
               if (w_start_drain) begin
                  r_state <= HALT_DRAIN;
                  r_cnt   <= DRAIN_DEPTH;
               end else begin
                  r_state <= HALT_RUN;
               end
               bus.halted <= 1'b0;
            end
            HALT_DRAIN: begin
               if (r_cnt == 2'd1) begin
                  r_state    <= HALT_HALTED;
                  bus.halted <= 1'b1;
               end else begin
                  r_state    <= HALT_DRAIN;
                  bus.halted <= 1'b0;
               end
               r_cnt <= r_cnt - 2'd1;
            end
            HALT_HALTED: begin
               r_state    <= HALT_HALTED;
               bus.halted <= 1'b1;
            end
            default: begin
               r_state    <= HALT_RUN;
               r_cnt      <= 2'd0;
               bus.halted <= 1'b0;
            end
         endcase
      end
   end

   fwd_unit u_fwd_a (
      .i_src      (bus.ex_rs),
      .i_mem_regw (bus.mem_regw),
      .i_mem_wreg (bus.mem_wreg),
      .i_wb_regw  (bus.wb_regw),
      .i_wb_wreg  (bus.wb_wreg),
      .o_sel      (bus.fwd_a)
   );

   fwd_unit u_fwd_b (
      .i_src      (bus.ex_rt),
      .i_mem_regw (bus.mem_regw),
      .i_mem_wreg (bus.mem_wreg),
      .i_wb_regw  (bus.wb_regw),
      .i_wb_wreg  (bus.wb_wreg),
      .o_sel      (bus.fwd_b)
   );
endmodule
